// File: rtl/pc_int_pkg.sv
// Shared types and constants for the PC-next / interrupt controller.
//   state_t      : controller FSM state (RUN / TAKE / HANDLER)
//   PC_INCR      : sequential fetch increment
//   DEF_INT_VEC  : default interrupt handler entry address
//   DEF_RESET_PC : default epc value after reset
package pc_int_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam logic [31:0] PC_INCR      = 32'd4;
  localparam logic [31:0] DEF_INT_VEC  = 32'h0000_0004;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/int_req_sync.sv
// Interrupt request front end: optional two-flop synchronizer, rising-edge
// detect and a sticky pending flag.
// Build option: define INT_SYNC_EN to insert the two-flop synchronizer
// (adds two cycles of request latency).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   int_req    : raw level interrupt request
//   take       : interrupt is being taken this cycle (clears pending)
//   pending    : registered pending-request flag
module int_req_sync (
  input  logic clk,
  input  logic reset,
  input  logic int_req,
  input  logic take,
  output logic pending
);

  logic edge_src;
  logic edge_hist;
  logic rise;

`ifdef INT_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= int_req;
      sync2 <= sync1;
    end
  end

  assign edge_src = sync2;
`else
  assign edge_src = int_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_hist <= 1'b0;
    end else begin
      edge_hist <= edge_src;
    end
  end

  assign rise = edge_src & ~edge_hist;

  // A fresh edge in the same cycle as a take is a new request and survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else begin
      pending <= (pending & ~take) | rise;
    end
  end

endmodule

// File: rtl/pc_next_int_ctrl.sv
// Next-PC selection with a single-level external interrupt controller.
// Build option: INT_SYNC_EN (two-flop synchronizer on INT, see int_req_sync).
// Parameters:
//   INT_VECTOR : handler entry address
//   RESET_PC   : epc value after reset
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   INT            : level interrupt request (rising edge = one request)
//   RFE            : return-from-exception decoded this cycle
//   stall          : pipeline hold
//   pc             : current PC
//   branch_taken   : branch resolved taken, with branch_target
//   jump           : unconditional jump, with jump_target
//   pc_next        : combinational next PC
//   epc            : saved return address
//   int_ack        : one-cycle pulse when an interrupt is taken
//   int_en         : high while in RUN
module pc_next_int_ctrl
  import pc_int_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR = DEF_INT_VEC,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        INT,
  input  logic        RFE,
  input  logic        stall,
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_next,
  output logic [31:0] epc,
  output logic        int_ack,
  output logic        int_en
);

  state_t      state;
  state_t      state_nxt;
  logic        pending;
  logic        take;
  logic [31:0] pc_normal;

  int_req_sync u_req (
    .clk     (clk),
    .reset   (reset),
    .int_req (INT),
    .take    (take),
    .pending (pending)
  );

  always_comb begin
    if (jump) begin
      pc_normal = jump_target;
    end else if (branch_taken) begin
      pc_normal = branch_target;
    end else begin
      pc_normal = pc + PC_INCR;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_next   = pc_normal;
    take      = 1'b0;
    if (stall) begin
      pc_next = pc;
    end else begin
      unique case (state)
        RUN: begin
          if (pending) begin
            pc_next   = INT_VECTOR;
            take      = 1'b1;
            state_nxt = TAKE;
          end
        end
        TAKE: begin
          state_nxt = HANDLER;
        end
        HANDLER: begin
          if (RFE) begin
            pc_next   = epc;
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      epc     <= RESET_PC;
      int_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      int_ack <= take;
      if (take) begin
        epc <= pc_normal;
      end
    end
  end

  assign int_en = (state == RUN);

endmodule

// File: tb/tb_pc_next_int_ctrl.sv
module tb_pc_next_int_ctrl;

  logic        clk;
  logic        reset;
  logic        INT;
  logic        RFE;
  logic        stall;
  logic [31:0] pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc_next;
  logic [31:0] epc;
  logic        int_ack;
  logic        int_en;

  int unsigned n_checks;
  int unsigned n_errors;

  pc_next_int_ctrl #(
    .INT_VECTOR (32'h0000_0004),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .INT           (INT),
    .RFE           (RFE),
    .stall         (stall),
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc_next       (pc_next),
    .epc           (epc),
    .int_ack       (int_ack),
    .int_en        (int_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock, leave inputs settled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    INT           = 1'b0;
    RFE           = 1'b0;
    stall         = 1'b0;
    pc            = 32'h0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_int_en", {31'd0, int_en}, 32'd1);
    check("rst_int_ack", {31'd0, int_ack}, 32'd0);
    check("rst_epc", epc, 32'h0);

    pc = 32'hFFFF_FFFC; #1;
    check("seq_wrap", pc_next, 32'h0);
    pc = 32'h1000; #1;
    check("seq", pc_next, 32'h1004);

    jump = 1'b1; branch_taken = 1'b1;
    jump_target = 32'h100; branch_target = 32'h200; #1;
    check("prio_jump", pc_next, 32'h100);
    jump = 1'b0; #1;
    check("branch", pc_next, 32'h200);
    branch_taken = 1'b0;

    RFE = 1'b1; pc = 32'h10; #1;
    check("rfe_in_run", pc_next, 32'h14);
    tick();
    check("rfe_in_run_state", {31'd0, int_en}, 32'd1);
    RFE = 1'b0;

    // interrupt take
    pc = 32'h40; INT = 1'b1; #1;
    check("int_edge_cycle", pc_next, 32'h44);
    tick();
    check("take_pc_next", pc_next, 32'h4);
    check("take_ack_low", {31'd0, int_ack}, 32'd0);
    tick();
    INT = 1'b0;
    pc = 32'h4; #1;
    check("take_epc", epc, 32'h44);
    check("take_ack", {31'd0, int_ack}, 32'd1);
    check("take_int_en", {31'd0, int_en}, 32'd0);
    check("take_state_pc", pc_next, 32'h8);
    tick();
    check("hnd_ack_gone", {31'd0, int_ack}, 32'd0);
    check("hnd_int_en", {31'd0, int_en}, 32'd0);

    // new request in HANDLER: pending but not taken
    INT = 1'b1;
    tick();
    INT = 1'b0;
    tick();
    pc = 32'h8; #1;
    check("hnd_masked", pc_next, 32'hC);
    RFE = 1'b1; #1;
    check("rfe_pc", pc_next, 32'h44);
    tick();
    RFE = 1'b0;
    check("rfe_run", {31'd0, int_en}, 32'd1);

    // pending held off by stall
    stall = 1'b1; pc = 32'h80;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_pc", pc_next, 32'h80);
      check("stall_ack", {31'd0, int_ack}, 32'd0);
      check("stall_run", {31'd0, int_en}, 32'd1);
      tick();
    end
    stall = 1'b0; #1;
    check("retake_pc", pc_next, 32'h4);
    tick();
    check("retake_ack", {31'd0, int_ack}, 32'd1);
    check("retake_epc", epc, 32'h84);

    // stall inside TAKE: ack only on first cycle
    stall = 1'b1;
    tick();
    check("take_stall_ack", {31'd0, int_ack}, 32'd0);
    check("take_stall_en", {31'd0, int_en}, 32'd0);
    check("take_stall_epc", epc, 32'h84);
    stall = 1'b0;
    tick();
    check("hnd2_en", {31'd0, int_en}, 32'd0);

    // reset mid-handler
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pc = 32'h200; #1;
    check("rst_hnd_en", {31'd0, int_en}, 32'd1);
    check("rst_hnd_epc", epc, 32'h0);
    check("rst_hnd_nopend", pc_next, 32'h204);
    tick();
    check("rst_hnd_noack", {31'd0, int_ack}, 32'd0);
    check("rst_hnd_run", pc_next, 32'h204);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_next_int_ctrl.md
PC_NEXT_INT_CTRL -- requirements
Module: pc_next_int_ctrl

Interface
REQ-001 Parameter INT_VECTOR, default 32'h0000_0004: handler entry address.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: value of epc after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 INT  input  1  external interrupt request, level; a rising edge is one request.
REQ-006 RFE  input  1  return-from-exception decoded this cycle.
REQ-007 stall  input  1  pipeline hold; the pc register must not advance.
REQ-008 pc  input  32  current PC, from the downstream PC register.
REQ-009 branch_taken  input  1  conditional branch resolved as taken.
REQ-010 branch_target  input  32  branch destination.
REQ-011 jump  input  1  unconditional jump.
REQ-012 jump_target  input  32  jump destination.
REQ-013 pc_next  output  32  combinational next PC, feeding the PC register.
REQ-014 epc  output  32  registered saved return address.
REQ-015 int_ack  output  1  registered one-cycle pulse when an interrupt is taken.
REQ-016 int_en  output  1  high when the FSM is in RUN.

Function
REQ-017 The normal next PC SHALL be computed as follows:
- jump_target if jump, else branch_target if branch_taken, else pc+4.
- pc+4 is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-018 The FSM SHALL have three states:
- RUN: normal fetch.
- TAKE: one-cycle acknowledge.
- HANDLER: interrupts masked.
REQ-019 A pending flag SHALL set on each rising edge of the (optionally synchronized) INT.
- It clears only when an interrupt is taken.
- Edges that arrive while pending is already set merge into the one request.
REQ-020 In RUN with pending=1 and stall=0, all of the following SHALL happen in that cycle:
- pc_next = INT_VECTOR.
- epc <= the normal next PC.
- pending clears.
- Next state is TAKE.
REQ-021 In TAKE, the block SHALL output int_ack=1 and the normal next PC, then go to HANDLER (stall holds it in TAKE with int_ack high only on the first cycle).
REQ-022 In HANDLER with RFE=1 and stall=0, the block SHALL drive pc_next = epc and go to RUN.
REQ-023 In HANDLER, new requests SHALL set pending but SHALL NOT be taken.
REQ-024 An RFE in RUN or TAKE SHALL be ignored, and pc_next stays the normal next PC.
REQ-025 When RFE and pending coincide in HANDLER, RFE SHALL win; the interrupt is taken on the first unstalled RUN cycle afterwards.
REQ-026 When stall=1, the block SHALL hold everything except pending:
- pc_next = pc.
- No FSM transition and no epc write.
- pending capture continues.
REQ-027 Priority SHALL be reset > stall > RFE (HANDLER) > interrupt take (RUN) > jump > branch > sequential.

Reset
REQ-028 On reset, the block SHALL load:
- state = RUN, pending = 0, epc = RESET_PC, int_ack = 0.
- Synchronizer flops and INT-edge history = 0.
REQ-029 A reset asserted in TAKE or HANDLER SHALL abandon the handler; the cycle after reset is RUN.

Configuration
REQ-030 With INT_SYNC_EN defined, INT SHALL pass through a two-flop synchronizer before edge detection, adding 2 cycles of request latency.
REQ-031 Without INT_SYNC_EN, INT SHALL feed edge detection directly, with one register stage for edge history only.

Structure
REQ-032 Package pc_int_pkg SHALL hold:
- the FSM state type (RUN/TAKE/HANDLER);
- the PC_INCR constant (4);
- the default vector and reset PC constants.
REQ-033 One sub-module, int_req_sync, SHALL contain the optional synchronizer, edge detect and pending flag.

Verification
REQ-034 Sequential wrap: reset, pc=32'hFFFF_FFFC, no controls -> pc_next=0.
REQ-035 Priority: jump=1, branch_taken=1, jump_target=32'h100, branch_target=32'h200 -> pc_next=32'h100.
REQ-036 Interrupt take, no sync: pc=32'h40, INT rises -> next cycle:
- pc_next=32'h4, epc<=32'h44;
- int_ack=1 for exactly one cycle after that;
- int_en=0.
REQ-037 Return: in HANDLER, INT pulses, then RFE with epc=32'h44 -> pc_next=32'h44, state RUN; the first unstalled RUN cycle then vectors to 32'h4 again.
REQ-038 Stall: pending set, stall=1 for 3 cycles, pc=32'h80 -> pc_next=32'h80 each cycle, no ack; the take occurs on the first cycle with stall=0.
REQ-039 Reset mid-handler: reset in HANDLER -> next cycle int_en=1, epc=0, pending=0.
